// File: rtl/wb_bram_sched_if.sv
// Writeback / read-requester / BRAM signal bundle for wb_bram_sched.
interface wb_bram_sched_if #(
    parameter int DW = 64,
    parameter int AW = 12
);
    logic          start;
    logic [3:0]    layer;
    logic [AW-1:0] base_addr;
    logic [7:0]    num_rows;
    logic          wr_valid;
    logic [DW-1:0] wr_data1;
    logic [DW-1:0] wr_data2;
    logic          wr_ready;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_data_valid;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr1;
    logic [AW-1:0] bram_addr2;
    logic [DW-1:0] bram_din1;
    logic [DW-1:0] bram_din2;
    logic [3:0]    cur_layer;
    logic          busy;
    logic          done;

    modport slave (
        input  start, layer, base_addr, num_rows,
        input  wr_valid, wr_data1, wr_data2,
        input  rd_req, rd_addr,
        output wr_ready, rd_gnt, rd_data_valid,
        output bram_en, bram_we, bram_addr1, bram_addr2, bram_din1, bram_din2,
        output cur_layer, busy, done
    );

    modport master (
        output start, layer, base_addr, num_rows,
        output wr_valid, wr_data1, wr_data2,
        output rd_req, rd_addr,
        input  wr_ready, rd_gnt, rd_data_valid,
        input  bram_en, bram_we, bram_addr1, bram_addr2, bram_din1, bram_din2,
        input  cur_layer, busy, done
    );
endinterface

// File: rtl/wb_bram_sched.sv
// Writeback FIFO, per-layer address generation and read/write BRAM arbitration.
// Optional macro WB_STARVE_GUARD_EN forces a write after 7 consecutive read wins over a pending write.
module wb_bram_sched #(
    parameter int DW            = 64,
    parameter int AW            = 12,
    parameter int FIFO_DEPTH    = 4,
    parameter int WORDS_PER_ROW = 5,
    parameter int PORT2_OFFSET  = 32
) (
    input  logic            clk,
    input  logic            rst,
    wb_bram_sched_if.slave  bus
);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FIFO_FULL = (PW+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [3:0]    r_layer;
    logic [AW-1:0] r_base;
    logic [11:0]   r_total;
    logic [11:0]   r_wcnt;
    logic [11:0]   r_pcnt;

    logic [DW-1:0] r_mem1 [FIFO_DEPTH];
    logic [DW-1:0] r_mem2 [FIFO_DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW:0]   r_count;

    logic          r_en;
    logic          r_we;
    logic          r_rdv;
    logic [AW-1:0] r_addr1;
    logic [AW-1:0] r_addr2;
    logic [DW-1:0] r_din1;
    logic [DW-1:0] r_din2;

    logic w_run;
    logic w_empty;
    logic w_full;
    logic w_wr_ready;
    logic w_push;
    logic w_wr_cand;
    logic w_rd_win;
    logic w_wr_win;

    assign w_run      = (r_state == S_RUN);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FIFO_FULL);
    assign w_wr_ready = w_run && !w_full && (r_pcnt != r_total);
    assign w_push     = bus.wr_valid && w_wr_ready;
    assign w_wr_cand  = w_run && !w_empty;

`ifdef WB_STARVE_GUARD_EN
    logic [2:0] r_starve;
    logic       w_force;

    assign w_force  = (r_starve == 3'd7) && w_wr_cand;
    assign w_rd_win = rst && bus.rd_req && !w_full && !w_force;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (w_wr_win) begin
            r_starve <= '0;
        end else if (w_rd_win && !w_empty) begin
            r_starve <= r_starve + 3'd1;
        end
    end
`else
    // rd_gnt is combinational, so it is gated by reset to keep it low while rst is held
    assign w_rd_win = rst && bus.rd_req && !w_full;
`endif

    assign w_wr_win = w_wr_cand && !w_rd_win;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem1[r_wp] <= bus.wr_data1;
            r_mem2[r_wp] <= bus.wr_data2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PW'(1);
            end
            if (w_wr_win) begin
                r_rp <= r_rp + PW'(1);
            end
            case ({w_push, w_wr_win})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_layer <= '0;
            r_base  <= '0;
            r_total <= '0;
            r_wcnt  <= '0;
            r_pcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_layer <= bus.layer;
                        r_base  <= bus.base_addr;
                        r_total <= 12'(bus.num_rows) * 12'(WORDS_PER_ROW);
                        r_wcnt  <= '0;
                        r_pcnt  <= '0;
                        r_state <= (bus.num_rows == 8'd0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_push) begin
                        r_pcnt <= r_pcnt + 12'd1;
                    end
                    if (w_wr_win) begin
                        r_wcnt <= r_wcnt + 12'd1;
                    end
                    // the last write reaches the BRAM bus in the cycle this condition first holds
                    if ((r_wcnt == r_total) && w_empty) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en    <= 1'b0;
            r_we    <= 1'b0;
            r_rdv   <= 1'b0;
            r_addr1 <= '0;
            r_addr2 <= '0;
            r_din1  <= '0;
            r_din2  <= '0;
        end else begin
            r_rdv <= r_en && !r_we;
            if (w_rd_win) begin
                r_en    <= 1'b1;
                r_we    <= 1'b0;
                r_addr1 <= bus.rd_addr;
            end else if (w_wr_win) begin
                r_en    <= 1'b1;
                r_we    <= 1'b1;
                r_addr1 <= r_base + AW'(r_wcnt);
                r_addr2 <= r_base + AW'(PORT2_OFFSET) + AW'(r_wcnt);
                r_din1  <= r_mem1[r_rp];
                r_din2  <= r_mem2[r_rp];
            end else begin
                r_en <= 1'b0;
                r_we <= 1'b0;
            end
        end
    end

    assign bus.wr_ready      = w_wr_ready;
    assign bus.rd_gnt        = w_rd_win;
    assign bus.rd_data_valid = r_rdv;
    assign bus.bram_en       = r_en;
    assign bus.bram_we       = r_we;
    assign bus.bram_addr1    = r_addr1;
    assign bus.bram_addr2    = r_addr2;
    assign bus.bram_din1     = r_din1;
    assign bus.bram_din2     = r_din2;
    assign bus.cur_layer     = r_layer;
    assign bus.busy          = w_run;
    assign bus.done          = (r_state == S_DONE);
endmodule

// File: tb/tb_wb_bram_sched.sv
// Self-checking bench for wb_bram_sched: layer job table, scoreboarded BRAM traffic, corner sequences.
module tb_wb_bram_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    wb_bram_sched_if #(.DW(64), .AW(12)) bus ();

    wb_bram_sched #(
        .DW(64), .AW(12), .FIFO_DEPTH(4), .WORDS_PER_ROW(5), .PORT2_OFFSET(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0]  layer;
        logic [11:0] base;
        logic [7:0]  rows;
        bit          reads;
        bit          gaps;
        int          exp_writes;
    } job_t;

    typedef struct {
        logic [11:0] a1;
        logic [11:0] a2;
        logic [63:0] d1;
        logic [63:0] d2;
    } wexp_t;

    job_t        jobs [4];
    wexp_t       wq [$];
    logic [11:0] rq [$];
    wexp_t       wpop;
    logic [11:0] rpop;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int done_cnt = 0;
    int done_lat = 0;
    int n_writes = 0;
    int n_acc = 0;
    int idx = 0;
    logic [11:0] cur_base = '0;
    bit gnt_d1 = 1'b0;
    bit gnt_d2 = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] outs();
        return 256'({bus.wr_ready, bus.rd_gnt, bus.rd_data_valid, bus.bram_en, bus.bram_we,
                     bus.bram_addr1, bus.bram_addr2, bus.bram_din1, bus.bram_din2,
                     bus.cur_layer, bus.busy, bus.done});
    endfunction

    // Scoreboard: expectations are queued when a pair is accepted or a read granted.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            wq.delete();
            rq.delete();
            gnt_d1 = 1'b0;
            gnt_d2 = 1'b0;
        end else begin
            if (bus.bram_en && bus.bram_we) begin
                n_writes++;
                last_we_cyc = cyc;
                chk("wr_queue_nonempty", 256'(wq.size() > 0), 256'(1));
                if (wq.size() > 0) begin
                    wpop = wq.pop_front();
                    chk("wr_bus", 256'({bus.bram_addr1, bus.bram_addr2, bus.bram_din1, bus.bram_din2}),
                        256'({wpop.a1, wpop.a2, wpop.d1, wpop.d2}));
                end
            end
            chk("rd_en", 256'(bus.bram_en && !bus.bram_we), 256'(gnt_d1));
            if (gnt_d1 && rq.size() > 0) begin
                rpop = rq.pop_front();
                chk("rd_addr", 256'(bus.bram_addr1), 256'(rpop));
            end
            chk("rd_data_valid", 256'(bus.rd_data_valid), 256'(gnt_d2));
            if (bus.done) begin
                done_cnt++;
                done_lat = cyc - last_we_cyc;
            end
            if (bus.wr_valid && bus.wr_ready) begin
                wq.push_back('{a1: cur_base + 12'(idx), a2: cur_base + 12'd32 + 12'(idx),
                               d1: bus.wr_data1, d2: bus.wr_data2});
                idx++;
                n_acc++;
            end
            if (bus.rd_gnt) begin
                rq.push_back(bus.rd_addr);
            end
            gnt_d2 = gnt_d1;
            gnt_d1 = bus.rd_gnt;
        end
    end

    task automatic begin_layer(input logic [3:0] lay, input logic [11:0] base, input logic [7:0] rows);
        cur_base = base;
        idx = 0;
        bus.layer = lay;
        bus.base_addr = base;
        bus.num_rows = rows;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send_pairs(input int n, input bit reads, input bit gaps);
        int sent = 0;
        int t = 0;
        bit acc;
        bit g;
        while (sent < n && t < 2000) begin
            bus.wr_valid = !gaps || ($urandom_range(0, 2) != 0);
            bus.wr_data1 = {$urandom(), $urandom()};
            bus.wr_data2 = {$urandom(), $urandom()};
            bus.rd_req = reads;
            #1;
            acc = bus.wr_valid && bus.wr_ready;
            g = bus.rd_gnt;
            step();
            if (acc) sent++;
            if (g) bus.rd_addr = 12'($urandom());
            t++;
        end
        bus.wr_valid = 1'b0;
        bus.rd_req = 1'b0;
        chk("send_complete", 256'(sent), 256'(n));
    endtask

    task automatic finish_layer(input int total, input int acc0, input int wr0, input int d0,
                                input logic [3:0] lay);
        int t = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data1 = {$urandom(), $urandom()};
        bus.wr_data2 = {$urandom(), $urandom()};
        #1;
        chk("wr_ready_past_total", 256'(bus.wr_ready), 256'(0));
        while (done_cnt == d0 && t < 300) begin
            step();
            t++;
        end
        bus.wr_valid = 1'b0;
        chk("done_in_time", 256'(t < 300), 256'(1));
        chk("done_latency", 256'(done_lat), 256'(1));
        chk("after_done_idle", 256'({bus.done, bus.busy}), 256'(0));
        chk("pairs_accepted", 256'(n_acc - acc0), 256'(total));
        chk("writes_issued", 256'(n_writes - wr0), 256'(total));
        chk("wq_drained", 256'(wq.size()), 256'(0));
        step();
        step();
        chk("done_single_pulse", 256'(done_cnt - d0), 256'(1));
        chk("cur_layer_hold", 256'(bus.cur_layer), 256'(lay));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, wr0, d0, w1, grants, exp_g, exp_w;
        bit g;

        jobs[0] = '{layer: 4'h3, base: 12'h010, rows: 8'd2, reads: 1'b0, gaps: 1'b0, exp_writes: 10};
        jobs[1] = '{layer: 4'h5, base: 12'hFFE, rows: 8'd1, reads: 1'b0, gaps: 1'b0, exp_writes: 5};
        jobs[2] = '{layer: 4'h9, base: 12'h200, rows: 8'd2, reads: 1'b1, gaps: 1'b0, exp_writes: 10};
        jobs[3] = '{layer: 4'hC, base: 12'h7F0, rows: 8'd3, reads: 1'b1, gaps: 1'b1, exp_writes: 15};

        bus.start = 1'b0;
        bus.layer = '0;
        bus.base_addr = '0;
        bus.num_rows = '0;
        bus.wr_valid = 1'b0;
        bus.wr_data1 = '0;
        bus.wr_data2 = '0;
        bus.rd_req = 1'b1;
        bus.rd_addr = 12'h3FF;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 256'(0));
        bus.rd_req = 1'b0;
        rst = 1'b1;
        step();

        for (int j = 0; j < 4; j++) begin
            acc0 = n_acc;
            wr0 = n_writes;
            d0 = done_cnt;
            begin_layer(jobs[j].layer, jobs[j].base, jobs[j].rows);
            chk("busy_in_run", 256'(bus.busy), 256'(1));
            chk("cur_layer_latched", 256'(bus.cur_layer), 256'(jobs[j].layer));
            send_pairs(jobs[j].exp_writes, jobs[j].reads, jobs[j].gaps);
            finish_layer(jobs[j].exp_writes, acc0, wr0, d0, jobs[j].layer);
        end

        bus.rd_req = 1'b1;
        bus.rd_addr = 12'h123;
        #1;
        chk("idle_rd_gnt", 256'(bus.rd_gnt), 256'(1));
        step();
        bus.rd_req = 1'b0;
        chk("idle_rd_bus", 256'({bus.bram_en, bus.bram_we, bus.bram_addr1, bus.rd_data_valid}),
            256'({1'b1, 1'b0, 12'h123, 1'b0}));
        step();
        chk("idle_rd_valid", 256'({bus.rd_data_valid, bus.bram_en}), 256'(2'b10));
        step();
        chk("idle_rd_valid_clear", 256'(bus.rd_data_valid), 256'(0));

        wr0 = n_writes;
        begin_layer(4'h7, 12'h0AA, 8'd0);
        chk("zero_rows_done", 256'({bus.done, bus.busy}), 256'(2'b10));
        step();
        chk("zero_rows_done_clear", 256'(bus.done), 256'(0));
        chk("zero_rows_no_write", 256'(n_writes - wr0), 256'(0));
        chk("zero_rows_layer", 256'(bus.cur_layer), 256'(4'h7));

        acc0 = n_acc;
        wr0 = n_writes;
        d0 = done_cnt;
        begin_layer(4'h2, 12'h040, 8'd1);
        send_pairs(2, 1'b0, 1'b0);
        bus.layer = 4'hF;
        bus.base_addr = 12'h999;
        bus.num_rows = 8'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_ignored", 256'({bus.cur_layer, bus.busy}), 256'({4'h2, 1'b1}));
        send_pairs(3, 1'b0, 1'b0);
        finish_layer(5, acc0, wr0, d0, 4'h2);

        acc0 = n_acc;
        wr0 = n_writes;
        d0 = done_cnt;
        begin_layer(4'h6, 12'h300, 8'd2);
        bus.rd_req = 1'b1;
        bus.rd_addr = 12'h0F0;
        bus.wr_valid = 1'b1;
        bus.wr_data1 = {$urandom(), $urandom()};
        bus.wr_data2 = {$urandom(), $urandom()};
        #1;
        chk("starve_first_push", 256'({bus.wr_ready, bus.rd_gnt}), 256'(2'b11));
        step();
        bus.wr_valid = 1'b0;
        bus.rd_addr = 12'($urandom());
        grants = 0;
        w1 = n_writes;
        for (int i = 0; i < 12; i++) begin
            #1;
            g = bus.rd_gnt;
            if (g) grants++;
            step();
            if (g) bus.rd_addr = 12'($urandom());
        end
`ifdef WB_STARVE_GUARD_EN
        exp_g = 11;
        exp_w = 1;
`else
        exp_g = 12;
        exp_w = 0;
`endif
        chk("starve_grants", 256'(grants), 256'(exp_g));
        chk("starve_writes", 256'(n_writes - w1), 256'(exp_w));
        bus.rd_req = 1'b0;
        repeat (3) step();
        chk("starve_drained", 256'(n_writes - wr0), 256'(1));

        bus.rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data1 = {$urandom(), $urandom()};
            bus.wr_data2 = {$urandom(), $urandom()};
            #1;
            chk("full_arbitration", 256'({bus.wr_ready, bus.rd_gnt}), (i == 4) ? 256'(0) : 256'(3));
            g = bus.rd_gnt;
            step();
            if (g) bus.rd_addr = 12'($urandom());
        end
        bus.wr_valid = 1'b0;
        bus.rd_req = 1'b0;
        send_pairs(4, 1'b0, 1'b0);
        finish_layer(10, acc0, wr0, d0, 4'h6);

        d0 = done_cnt;
        begin_layer(4'hA, 12'h500, 8'd2);
        send_pairs(3, 1'b0, 1'b0);
        bus.rd_req = 1'b1;
        bus.rd_addr = 12'h055;
        rst = 1'b0;
        #1;
        chk("reset_midrun_outputs", outs(), 256'(0));
        step();
        step();
        bus.rd_req = 1'b0;
        rst = 1'b1;
        repeat (10) step();
        chk("reset_no_done", 256'(done_cnt - d0), 256'(0));
        chk("reset_idle", 256'({bus.busy, bus.wr_ready, bus.bram_en}), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
